// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared constants, state encodings and event record for the PS/2 receiver
package ps2_pkg;

  localparam logic [7:0] PFX_E0 = 8'hE0;
  localparam logic [7:0] PFX_F0 = 8'hF0;

  localparam logic [1:0] FR_IDLE  = 2'd0;
  localparam logic [1:0] FR_RECV  = 2'd1;
  localparam logic [1:0] FR_CHECK = 2'd2;

  localparam logic [1:0] PF_BASE = 2'd0;
  localparam logic [1:0] PF_E0   = 2'd1;
  localparam logic [1:0] PF_F0   = 2'd2;
  localparam logic [1:0] PF_E0F0 = 2'd3;

  localparam int EVT_W = 10;

  typedef struct packed {
    logic       ext;
    logic       rel;
    logic [7:0] code;
  } evt_t;

  // Frame bit 0 is the start bit, bits 8:1 data, bit 9 parity, bit 10 stop.
  function automatic logic frame_ok(input logic [10:0] f);
    return !f[0] && f[10] && (^f[9:1]);
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// rtl/ps2_evt_fifo.sv - event FIFO with extra-bit pointers and drop-on-full write
module ps2_evt_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             valid,
  output logic             drop
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             empty;
  logic             full;
  logic             pop;
  logic             push;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = rd_en && !empty;
  // A pop in the same cycle frees the slot, so a write to a full FIFO still lands.
  assign push  = wr_en && (!full || pop);
  assign drop  = wr_en && full && !pop;
  assign valid = !empty;
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// rtl/ps2_keyboard_rx.sv - PS/2 keyboard frame receiver with prefix decoding and event FIFO
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int CLK_DIV       = 250,
  parameter int TIMEOUT_TICKS = 4000,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  output logic       EVT_VALID,
  input  logic       EVT_READY,
  output logic [7:0] EVT_CODE,
  output logic       EVT_EXT,
  output logic       EVT_REL,
  output logic       OVERFLOW,
  output logic [7:0] ERR_COUNT
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);

  logic [1:0]    clk_sync;
  logic [1:0]    data_sync;
  logic [DW-1:0] div_cnt;
  logic          tick;
  logic          prev_clk;
  logic          fall;
  logic [1:0]    fr_state;
  logic [10:0]   shift;
  logic [3:0]    bit_cnt;
  logic [TW-1:0] to_cnt;
  logic [1:0]    pf_state;
  logic [7:0]    rx_byte;
  logic          wr_en;
  evt_t          wr_evt;
  evt_t          head;
  logic          drop;

  assign tick    = (div_cnt == DW'(CLK_DIV - 1));
  assign fall    = tick && prev_clk && !clk_sync[1];
  assign rx_byte = shift[8:1];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      div_cnt   <= '0;
      prev_clk  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], PS2_CLK};
      data_sync <= {data_sync[0], PS2_DATA};
      div_cnt   <= tick ? '0 : div_cnt + 1'b1;
      if (tick) prev_clk <= clk_sync[1];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      fr_state <= FR_IDLE;
      shift    <= '0;
      bit_cnt  <= '0;
      to_cnt   <= '0;
    end else begin
      case (fr_state)
        FR_IDLE: begin
          if (fall) begin
            shift    <= {data_sync[1], shift[10:1]};
            bit_cnt  <= 4'd1;
            to_cnt   <= '0;
            fr_state <= FR_RECV;
          end
        end
        FR_RECV: begin
          if (fall) begin
            shift   <= {data_sync[1], shift[10:1]};
            bit_cnt <= bit_cnt + 1'b1;
            to_cnt  <= '0;
            if (bit_cnt == 4'd10) fr_state <= FR_CHECK;
          end else if (tick) begin
            // Silent bus mid-frame: drop the partial frame without counting an error.
            if (to_cnt == TW'(TIMEOUT_TICKS - 1)) begin
              fr_state <= FR_IDLE;
              shift    <= '0;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end
        end
        FR_CHECK: if (tick) fr_state <= FR_IDLE;
        default:  fr_state <= FR_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pf_state  <= PF_BASE;
      ERR_COUNT <= '0;
      wr_en     <= 1'b0;
      wr_evt    <= '0;
    end else begin
      wr_en <= 1'b0;
      if (fr_state == FR_CHECK && tick) begin
        if (!frame_ok(shift)) begin
          pf_state <= PF_BASE;
          if (ERR_COUNT != 8'hFF) ERR_COUNT <= ERR_COUNT + 1'b1;
        end else if (rx_byte == PFX_E0) begin
          pf_state <= PF_E0;
        end else if (rx_byte == PFX_F0 && pf_state == PF_BASE) begin
          pf_state <= PF_F0;
        end else if (rx_byte == PFX_F0 && pf_state == PF_E0) begin
          pf_state <= PF_E0F0;
        end else begin
          wr_en       <= 1'b1;
          wr_evt.ext  <= (pf_state == PF_E0) || (pf_state == PF_E0F0);
          wr_evt.rel  <= (pf_state == PF_F0) || (pf_state == PF_E0F0);
          wr_evt.code <= rx_byte;
          pf_state    <= PF_BASE;
        end
      end
    end
  end

  ps2_evt_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(EVT_W)
  ) u_fifo (
    .clk    (CLK),
    .rst_n  (RST_N),
    .wr_en  (wr_en),
    .wr_data(wr_evt),
    .rd_en  (EVT_READY),
    .rd_data(head),
    .valid  (EVT_VALID),
    .drop   (drop)
  );

  assign EVT_CODE = head.code;
  assign EVT_EXT  = head.ext;
  assign EVT_REL  = head.rel;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)    OVERFLOW <= 1'b0;
    else if (drop) OVERFLOW <= 1'b1;
  end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// tb/tb_ps2_keyboard_rx.sv - self-checking bench for ps2_keyboard_rx
module tb_ps2_keyboard_rx;

  localparam int CLK_DIV = 4;
  localparam int TO      = 20;
  localparam int DEPTH   = 4;
  localparam int HALF    = 12;
  localparam int GAP     = 40;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       PS2_CLK;
  logic       PS2_DATA;
  logic       EVT_VALID;
  logic       EVT_READY;
  logic [7:0] EVT_CODE;
  logic       EVT_EXT;
  logic       EVT_REL;
  logic       OVERFLOW;
  logic [7:0] ERR_COUNT;

  logic ready_man = 1'b0;
  logic ready_rnd = 1'b0;
  logic rnd_en    = 1'b0;
  assign EVT_READY = rnd_en ? ready_rnd : ready_man;

  int checks = 0;
  int errors = 0;

  logic [9:0] exp_q[$];
  int         m_err;
  bit         m_ext;
  bit         m_rel;

  ps2_keyboard_rx #(
    .CLK_DIV(CLK_DIV),
    .TIMEOUT_TICKS(TO),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .PS2_CLK(PS2_CLK), .PS2_DATA(PS2_DATA),
    .EVT_VALID(EVT_VALID), .EVT_READY(EVT_READY), .EVT_CODE(EVT_CODE),
    .EVT_EXT(EVT_EXT), .EVT_REL(EVT_REL), .OVERFLOW(OVERFLOW), .ERR_COUNT(ERR_COUNT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // kind: 0 good, 1 bad parity, 2 bad start, 3 bad stop
  function automatic logic [10:0] mk_frame(input logic [7:0] b, input int kind);
    logic [10:0] f;
    f = {1'b1, ~^b, b, 1'b0};
    if (kind == 1) f[9]  = ~f[9];
    if (kind == 2) f[0]  = 1'b1;
    if (kind == 3) f[10] = 1'b0;
    return f;
  endfunction

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      PS2_DATA = f[i];
      PS2_CLK  = 1'b1;
      wait_cyc(HALF);
      PS2_CLK  = 1'b0;
      wait_cyc(HALF);
    end
    PS2_CLK  = 1'b1;
    PS2_DATA = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input int kind);
    send_bits(mk_frame(b, kind), 11);
    wait_cyc(GAP);
  endtask

  task automatic pop_one();
    @(negedge CLK);
    ready_man = 1'b1;
    @(negedge CLK);
    ready_man = 1'b0;
  endtask

  // Reference: pending prefix flags and an ordered queue of expected events.
  task automatic model_byte(input logic [7:0] b, input bit good);
    if (!good) begin
      if (m_err < 255) m_err++;
      m_ext = 0;
      m_rel = 0;
    end else if (b == 8'hE0) begin
      m_ext = 1;
      m_rel = 0;
    end else if (b == 8'hF0 && !m_rel) begin
      m_rel = 1;
    end else begin
      exp_q.push_back({m_ext, m_rel, b});
      m_ext = 0;
      m_rel = 0;
    end
  endtask

  logic       hold_v = 1'b0;
  logic [9:0] hold_d;

  always @(negedge CLK) begin
    if (rnd_en) begin
      if (hold_v && EVT_VALID)
        check("rnd_stable", {EVT_EXT, EVT_REL, EVT_CODE}, hold_d);
      hold_v = EVT_VALID && !EVT_READY;
      hold_d = {EVT_EXT, EVT_REL, EVT_CODE};
      if (EVT_VALID && EVT_READY) begin
        if (exp_q.size() == 0) check("rnd_unexpected_evt", {EVT_EXT, EVT_REL, EVT_CODE}, 32'hFFFF);
        else check("rnd_evt", {EVT_EXT, EVT_REL, EVT_CODE}, exp_q.pop_front());
      end
    end else begin
      hold_v = 1'b0;
    end
  end

  always @(posedge CLK) begin
    #1 ready_rnd = 1'($urandom_range(0, 1));
  end

  typedef struct {
    logic [7:0] data;
    int         kind;
    bit         exp_valid;
    logic [7:0] code;
    bit         ext;
    bit         rel;
    logic [7:0] err;
  } vec_t;

  vec_t tbl[9];

  initial begin
    logic [7:0] b;
    int         kind;
    int         budget;
    logic [7:0] err_before;

    tbl = '{
      '{8'h6B, 0, 1'b1, 8'h6B, 1'b0, 1'b0, 8'd0},
      '{8'hE0, 0, 1'b0, 8'h00, 1'b0, 1'b0, 8'd0},
      '{8'hF0, 0, 1'b0, 8'h00, 1'b0, 1'b0, 8'd0},
      '{8'h74, 0, 1'b1, 8'h74, 1'b1, 1'b1, 8'd0},
      '{8'h1C, 1, 1'b0, 8'h00, 1'b0, 1'b0, 8'd1},
      '{8'h1C, 0, 1'b1, 8'h1C, 1'b0, 1'b0, 8'd1},
      '{8'hE0, 0, 1'b0, 8'h00, 1'b0, 1'b0, 8'd1},
      '{8'h12, 3, 1'b0, 8'h00, 1'b0, 1'b0, 8'd2},
      '{8'h12, 0, 1'b1, 8'h12, 1'b0, 1'b0, 8'd2}
    };

    RST_N    = 1'b0;
    PS2_CLK  = 1'b1;
    PS2_DATA = 1'b1;
    wait_cyc(4);
    check("reset_valid", EVT_VALID, 0);
    check("reset_head", {EVT_EXT, EVT_REL, EVT_CODE}, 0);
    check("reset_ovf", OVERFLOW, 0);
    check("reset_err", ERR_COUNT, 0);
    RST_N = 1'b1;
    wait_cyc(8);

    for (int i = 0; i < 9; i++) begin
      send_frame(tbl[i].data, tbl[i].kind);
      check($sformatf("vec%0d_valid", i), EVT_VALID, tbl[i].exp_valid);
      if (tbl[i].exp_valid)
        check($sformatf("vec%0d_evt", i), {EVT_EXT, EVT_REL, EVT_CODE},
              {tbl[i].ext, tbl[i].rel, tbl[i].code});
      check($sformatf("vec%0d_err", i), ERR_COUNT, tbl[i].err);
      if (EVT_VALID) pop_one();
      check($sformatf("vec%0d_drained", i), EVT_VALID, 0);
    end

    err_before = ERR_COUNT;
    send_bits(mk_frame(8'h55, 0), 5);
    wait_cyc((TO + 1) * CLK_DIV + 8);
    check("timeout_no_evt", EVT_VALID, 0);
    send_frame(8'h72, 0);
    check("timeout_evt", {EVT_VALID, EVT_EXT, EVT_REL, EVT_CODE}, {1'b1, 10'h072});
    check("timeout_err", ERR_COUNT, err_before);
    pop_one();
    check("timeout_single", EVT_VALID, 0);

    for (int i = 1; i <= 5; i++) send_frame(8'(i * 8'h11), 0);
    check("ovf_flag", OVERFLOW, 1);
    @(negedge CLK);
    ready_man = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("ovf_pop%0d", i), {EVT_VALID, EVT_CODE}, {1'b1, 8'(i * 8'h11)});
      @(negedge CLK);
    end
    check("ovf_empty", EVT_VALID, 0);
    ready_man = 1'b0;

    send_frame(8'h33, 0);
    send_bits(mk_frame(8'h29, 0), 6);
    RST_N = 1'b0;
    #2;
    check("rst_mid_valid", EVT_VALID, 0);
    check("rst_mid_head", {EVT_EXT, EVT_REL, EVT_CODE}, 0);
    check("rst_mid_ovf", OVERFLOW, 0);
    check("rst_mid_err", ERR_COUNT, 0);
    wait_cyc(3);
    RST_N = 1'b1;
    wait_cyc(8);
    send_frame(8'h75, 0);
    check("rst_after_evt", {EVT_VALID, EVT_EXT, EVT_REL, EVT_CODE}, {1'b1, 10'h075});
    pop_one();

    m_err = 0;
    m_ext = 0;
    m_rel = 0;
    wait_cyc(1);
    rnd_en = 1'b1;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 9))
        0, 1:    b = 8'hE0;
        2, 3:    b = 8'hF0;
        default: b = 8'($urandom);
      endcase
      kind = ($urandom_range(0, 7) < 3) ? int'($urandom_range(1, 3)) : 0;
      model_byte(b, kind == 0);
      send_frame(b, kind);
    end
    budget = 0;
    while (exp_q.size() != 0 && budget < 2000) begin
      wait_cyc(1);
      budget++;
    end
    check("rnd_all_popped", exp_q.size(), 0);
    check("rnd_err", ERR_COUNT, m_err);
    check("rnd_ovf", OVERFLOW, 0);
    rnd_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
